wallace_mul_arbiter: RTL
========================

Name: wallace_mul_arbiter

Overview:
- Shares one combinational 16x16 Wallace-tree multiplier among NREQ requesters using a round-robin policy.
- Registers the winning operands and holds them stable on the multiplier inputs for MUL_CYCLES cycles, because the tree is used as a multicycle path.
- Captures the 32-bit product and returns it with the requester ID over a valid/ready response channel.
- Sits between the requesting datapath units and the multiplier instance; exactly one multiply is in flight at any time.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of resp_id; must satisfy 2**IDW >= NREQ.
- MUL_CYCLES, 2, number of cycles operands are held before the product is sampled; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  16*NREQ  multiplicand; requester i uses bits [16i+15:16i].
- req_b  in  16*NREQ  multiplier; same packing as req_a.
- mul_a  out  16  operand A to the Wallace multiplier, registered.
- mul_b  out  16  operand B to the Wallace multiplier, registered.
- mul_prod  in  32  product from the Wallace multiplier.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_prod  out  32  registered product.
- busy  out  1  high whenever state is not IDLE.
- op_count  out  16  count of completed responses; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - last_grant = NREQ-1, so requester 0 has top priority after reset.
  - mul_a, mul_b, resp_prod, resp_id, op_count = 0; resp_valid = 0; busy = 0.
  - Reset has priority over every other event. A transaction in progress is abandoned and produces no response.
- req_ready is combinational. It is asserted only in IDLE, for exactly the granted index g, and only while req_valid[g]=1. In all other states req_ready = 0.
- Arbitration in IDLE:
  - g is the first index with req_valid set, searching last_grant+1, last_grant+2, ... modulo NREQ.
  - Indices whose req_valid is low are skipped.
  - If no req_valid is set, the block stays in IDLE.
- Handshake cycle T (IDLE with at least one req_valid):
  - At the edge, mul_a <- req_a[g], mul_b <- req_b[g], resp_id <- g, last_grant <- g.
  - Counter cnt <- MUL_CYCLES-1; state goes to WAIT.
- WAIT:
  - mul_a and mul_b are held constant.
  - If cnt != 0, decrement cnt.
  - If cnt == 0: resp_prod <- mul_prod, resp_valid <- 1, state goes to RESP.
  - WAIT lasts exactly MUL_CYCLES cycles; resp_valid first rises in cycle T+MUL_CYCLES+1.
- RESP:
  - resp_valid, resp_prod and resp_id are held stable until resp_valid && resp_ready is seen at an edge.
  - At that edge: resp_valid <- 0, op_count increments (saturating), state goes to IDLE.
  - There is no grant in the same cycle as the response handshake. The minimum issue interval is MUL_CYCLES+2 cycles.
- Requester-side rules:
  - Each requester must hold req_valid and its operands until req_ready is seen.
  - A requester may drop req_valid before being granted; the arbiter then simply skips it.
- Width: the product is the full 32-bit unsigned A*B with no truncation. mul_prod is treated as valid only at the WAIT cnt==0 edge.
- busy = (state != IDLE).

Test Plan:
- Basic latency (MUL_CYCLES=2): after reset, req_valid=4'b0001, A=0xFFFF, B=0xFFFF.
  - req_ready[0]=1 in cycle T.
  - resp_valid=1 from cycle T+3 with resp_prod=0xFFFE0001, resp_id=0.
  - resp_ready=1 in that cycle gives op_count=1.
- Round-robin fairness: all four req_valid held high with resp_ready=1.
  - Grant order is 0,1,2,3,0.
  - Consecutive req_ready pulses are 4 cycles apart.
  - Every resp_id matches its grant.
- Round-robin skipping: last_grant=1, req_valid=4'b1010 -> grant 3. Next, with req_valid=4'b0010 -> grant 1.
- Response backpressure: resp_ready held low for 5 cycles.
  - resp_valid, resp_prod and resp_id stay stable; busy=1.
  - All req_ready stay 0, and mul_a/mul_b do not change.
- Reset mid-operation: rst asserted during WAIT.
  - resp_valid is never raised for that operation; op_count=0.
  - With req_valid=4'b1111 afterwards, requester 0 is granted first.
- Arithmetic corners:
  - A=0x1234, B=0x0000 -> 0x00000000.
  - A=0x00FF, B=0x0101 -> 0x0000FFFF.
  - A=0x8000, B=0x0002 -> 0x00010000.
  - Run with MUL_CYCLES=1 (resp_valid at T+2) and with MUL_CYCLES=4 (resp_valid at T+5).

Source files
------------

// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end that shares one external combinational 16x16 Wallace multiplier.
// Operands are registered and held MUL_CYCLES cycles so the tree can be timed as a multicycle path.
module wallace_mul_arbiter #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_prod,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [31:0]          resp_prod,
    output logic                 busy,
    output logic [15:0]          op_count
);
    localparam int              CNTW      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNTW-1:0] CNT_INIT  = CNTW'(MUL_CYCLES - 1);
    localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_last_grant;
    logic [CNTW-1:0] r_cnt;
    logic [15:0]     r_mul_a;
    logic [15:0]     r_mul_b;
    logic [31:0]     r_resp_prod;
    logic [IDW-1:0]  r_resp_id;
    logic            r_resp_valid;
    logic [15:0]     r_op_count;

    logic [IDW-1:0]  w_grant;
    logic [NREQ-1:0] w_onehot;
    logic            w_any;
    logic [15:0]     w_op_a;
    logic [15:0]     w_op_b;
    logic            w_take;
    logic            w_sample;
    logic            w_done;

    // Winner is the valid index with the smallest cyclic distance past last_grant.
    always_comb begin
        int d;
        int best;
        w_grant  = '0;
        w_onehot = '0;
        w_any    = 1'b0;
        d        = 0;
        best     = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(r_last_grant) - 1;
            if (d < 0) d = d + NREQ;
            if (req_valid[i] && d < best) begin
                best        = d;
                w_grant     = IDW'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
                w_any       = 1'b1;
            end
        end
    end

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_op_a = req_a[16*i +: 16];
                w_op_b = req_b[16*i +: 16];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_take      = 1'b0;
        w_sample    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    req_ready   = w_onehot;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= LAST_INIT;
            r_cnt        <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_resp_prod  <= '0;
            r_resp_id    <= '0;
            r_resp_valid <= 1'b0;
            r_op_count   <= '0;
        end else begin
            if (w_take) begin
                r_mul_a      <= w_op_a;
                r_mul_b      <= w_op_b;
                r_resp_id    <= w_grant;
                r_last_grant <= w_grant;
                r_cnt        <= CNT_INIT;
            end else if (r_state == S_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
            // mul_prod is only trusted on the last hold cycle.
            if (w_sample) begin
                r_resp_prod  <= mul_prod;
                r_resp_valid <= 1'b1;
            end
            if (w_done) begin
                r_resp_valid <= 1'b0;
                if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_prod  = r_resp_prod;
    assign busy       = (r_state != S_IDLE);
    assign op_count   = r_op_count;
endmodule
